// File: rtl/pwm_duty_sequencer.sv
// Duty-cycle sequencer for the PWM core: walks a small duty table and holds each
// entry for a programmable number of PWM periods, with optional looping.
module pwm_duty_sequencer #(
    parameter  int DEPTH = 16,
    parameter  int DW    = 16,
    parameter  int RW    = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          tbl_we_i,
    input  logic [AW-1:0] tbl_addr_i,
    input  logic [DW-1:0] tbl_wdata_i,
    input  logic [AW-1:0] seq_len_i,
    input  logic [RW-1:0] repeat_i,
    input  logic          loop_i,
    input  logic          start_i,
    input  logic          stop_i,
    input  logic          period_done_i,
    output logic [DW-1:0] duty_o,
    output logic          duty_upd_o,
    output logic [AW-1:0] step_o,
    output logic          busy_o,
    output logic          done_o
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [AW-1:0] FIRST_STEP = '0;

    state_t        state;
    logic [DW-1:0] tbl [DEPTH];
    logic [AW-1:0] len_sh;
    logic [RW-1:0] rep_sh;
    logic          loop_sh;
    logic [AW-1:0] idx;
    logic [AW-1:0] idx_next;
    logic [RW-1:0] rep_cnt;
    logic [DW-1:0] duty;
    logic          duty_upd;
    logic          busy;
    logic          done;

    // A repeat count of zero behaves like one so every step spans at least one period.
    function automatic logic [RW-1:0] at_least_one(input logic [RW-1:0] r);
        return (r == '0) ? RW'(1) : r;
    endfunction

    assign idx_next = idx + AW'(1);

    // Table loads read the pre-edge contents, so a same-edge write to the loaded
    // entry only shows up the next time that entry is visited.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state    <= IDLE;
            tbl      <= '{default: '0};
            len_sh   <= '0;
            rep_sh   <= '0;
            loop_sh  <= 1'b0;
            idx      <= '0;
            rep_cnt  <= '0;
            duty     <= '0;
            duty_upd <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            duty_upd <= 1'b0;
            done     <= 1'b0;

            if (tbl_we_i) begin
                tbl[tbl_addr_i] <= tbl_wdata_i;
            end

            case (state)
                IDLE: begin
                    if (start_i && !stop_i) begin
                        len_sh   <= seq_len_i;
                        rep_sh   <= at_least_one(repeat_i);
                        loop_sh  <= loop_i;
                        idx      <= FIRST_STEP;
                        duty     <= tbl[FIRST_STEP];
                        duty_upd <= 1'b1;
                        rep_cnt  <= at_least_one(repeat_i);
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (stop_i) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (period_done_i) begin
                        if (rep_cnt > RW'(1)) begin
                            rep_cnt <= rep_cnt - RW'(1);
                        end else if (idx < len_sh) begin
                            idx      <= idx_next;
                            duty     <= tbl[idx_next];
                            duty_upd <= 1'b1;
                            rep_cnt  <= rep_sh;
                        end else if (loop_sh) begin
                            idx      <= FIRST_STEP;
                            duty     <= tbl[FIRST_STEP];
                            duty_upd <= 1'b1;
                            rep_cnt  <= rep_sh;
                        end else begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign duty_o     = duty;
    assign duty_upd_o = duty_upd;
    assign step_o     = idx;
    assign busy_o     = busy;
    assign done_o     = done;

endmodule
